// File: rtl/axil_uart_arb_pkg.sv
// Shared state encoding, requester id type and AXI response codes for the
// UartLite AXI-lite arbiter.
package axil_uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RESP  = 3'd5
    } arb_state_t;

    // Index of a requester; only two exist, so one bit suffices.
    typedef logic req_id_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_uart_arb_pick.sv
// Two-way grant selection with the last-grant register.
// Build option: UART_ARB_FIXED_PRIO_EN makes requester 0 win every contention.
module axil_uart_arb_pick
    import axil_uart_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_valid0,
    input  logic    i_valid1,
    input  logic    i_update,
    output req_id_t o_grant
);

`ifdef UART_ARB_FIXED_PRIO_EN

    logic w_unused_rr;

    assign o_grant     = i_valid0 ? 1'b0 : i_valid1;
    assign w_unused_rr = ^{clk, rst, i_update};

`else

    req_id_t r_last_grant;

    // Under contention the requester not served last time wins.
    assign o_grant = (i_valid0 && i_valid1) ? ~r_last_grant : i_valid1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (i_update) begin
            r_last_grant <= o_grant;
        end
    end

`endif

endmodule

// File: rtl/axil_uart_arbiter.sv
// Shares one AXI-lite master port to the UartLite register block between two
// single-beat valid/ready requesters. Build option: UART_ARB_FIXED_PRIO_EN.
module axil_uart_arbiter
    import axil_uart_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic [3:0]        req0_wstrb,
    output logic              resp0_valid,
    output logic [31:0]       resp0_rdata,
    output logic              resp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    input  logic [3:0]        req1_wstrb,
    output logic              resp1_valid,
    output logic [31:0]       resp1_rdata,
    output logic              resp1_err,

    output logic [31:0]       m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [31:0]       m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    arb_state_t        r_state;
    req_id_t           r_gid;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_resp0_valid;
    logic              r_resp1_valid;

    logic              w_idle;
    logic              w_any;
    logic              w_accept;
    req_id_t           w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_wstrb;
    logic              w_aw_fin;
    logic              w_w_fin;
    logic [31:0]       w_addr;

    axil_uart_arb_pick u_pick (
        .clk      (clk),
        .rst      (rst),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_update (w_accept),
        .o_grant  (w_grant)
    );

    assign w_idle   = (r_state == ST_IDLE);
    assign w_any    = req0_valid | req1_valid;
    assign w_accept = w_idle & w_any;

    assign req0_ready = w_accept & (w_grant == 1'b0);
    assign req1_ready = w_accept & (w_grant == 1'b1);

    assign w_sel_we    = w_grant ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;
    assign w_sel_wstrb = w_grant ? req1_wstrb : req0_wstrb;

    // A channel counts as finished if it completed earlier or handshakes now.
    assign w_aw_fin = r_aw_done | (r_awvalid & m_awready);
    assign w_w_fin  = r_w_done  | (r_wvalid  & m_wready);

    assign w_addr = BASE_ADDR | 32'(r_addr);

    assign m_araddr  = w_addr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;
    assign m_awaddr  = w_addr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;

    assign resp0_valid = r_resp0_valid;
    assign resp0_rdata = r_rdata;
    assign resp0_err   = r_err;
    assign resp1_valid = r_resp1_valid;
    assign resp1_rdata = r_rdata;
    assign resp1_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_gid         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gid   <= w_grant;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wstrb <= w_sel_wstrb;
                        if (w_sel_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_A;
                        end
                    end
                end
                ST_RD_A: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (m_rvalid) begin
                        r_rready      <= 1'b0;
                        r_rdata       <= m_rdata;
                        r_err         <= resp_is_err(m_rresp);
                        r_resp0_valid <= (r_gid == 1'b0);
                        r_resp1_valid <= (r_gid == 1'b1);
                        r_state       <= ST_RESP;
                    end
                end
                ST_WR_AW: begin
                    if (r_awvalid && m_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && m_wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (m_bvalid) begin
                        r_bready      <= 1'b0;
                        r_rdata       <= '0;
                        r_err         <= resp_is_err(m_bresp);
                        r_resp0_valid <= (r_gid == 1'b0);
                        r_resp1_valid <= (r_gid == 1'b1);
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_resp0_valid <= 1'b0;
                    r_resp1_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_uart_arbiter.sv
// Directed, table-driven bench for axil_uart_arbiter with a configurable AXI-lite slave model.
module tb_axil_uart_arbiter;
    import axil_uart_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req0_valid = 1'b0, req0_ready, req0_we = 1'b0;
    logic [11:0] req0_addr = '0;
    logic [31:0] req0_wdata = '0;
    logic [3:0]  req0_wstrb = '0;
    logic        resp0_valid, resp0_err;
    logic [31:0] resp0_rdata;

    logic        req1_valid = 1'b0, req1_ready, req1_we = 1'b0;
    logic [11:0] req1_addr = '0;
    logic [31:0] req1_wdata = '0;
    logic [3:0]  req1_wstrb = '0;
    logic        resp1_valid, resp1_err;
    logic [31:0] resp1_rdata;

    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [3:0]  m_wstrb;
    logic        m_arready = 1'b0, m_rvalid = 1'b0, m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0, m_bresp = '0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    int          cfg_ar_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp = RESP_OKAY;
    bit          cfg_rvalid_en = 1'b1;

    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    bit          pend_r = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    axil_uart_arbiter #(.ADDR_W(12), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave bookkeeping: wait counters, handshake counts, captured payloads.
    always @(posedge clk) begin
        if (!rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            pend_r <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (m_arvalid && m_arready) begin
                ar_cnt <= 0; pend_r <= 1'b1; ar_hs <= ar_hs + 1; last_araddr <= m_araddr;
            end else if (m_arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (m_rvalid && m_rready) pend_r <= 1'b0;
            if (m_bvalid && m_bready) begin
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (m_awvalid && m_awready) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_hs <= aw_hs + 1; last_awaddr <= m_awaddr;
            end else if (m_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid && m_wready) begin
                w_cnt <= 0; w_got <= 1'b1; w_hs <= w_hs + 1;
                last_wdata <= m_wdata; last_wstrb <= m_wstrb;
            end else if (m_wvalid) begin
                w_cnt <= w_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        m_arready = m_arvalid && (ar_cnt == cfg_ar_wait);
        m_awready = m_awvalid && (aw_cnt == cfg_aw_wait);
        m_wready  = m_wvalid  && (w_cnt  == cfg_w_wait);
        m_rvalid  = pend_r && cfg_rvalid_en;
        m_rdata   = m_rvalid ? cfg_rdata : 32'h0;
        m_rresp   = cfg_resp;
        m_bvalid  = aw_got && w_got;
        m_bresp   = cfg_resp;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int id, input bit v, input bit we, input logic [11:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd; req0_wstrb = ws;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd; req1_wstrb = ws;
        end
    endtask

    task automatic wait_ready(input int id, output int t);
        int n = 0;
        #1;
        while ((((id == 0) ? req0_ready : req1_ready) !== 1'b1) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        t = cyc;
        check($sformatf("ready_wait_req%0d", id), 32'(n < 100), 32'd1);
    endtask

    task automatic wait_resp(output int sid, output logic [31:0] rd, output logic er, output int t);
        bit found = 1'b0;
        sid = 2; rd = '0; er = 1'b0; t = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk); #1;
            if (resp0_valid || resp1_valid) begin
                found = 1'b1;
                sid = (resp0_valid && resp1_valid) ? 3 : (resp1_valid ? 1 : 0);
                rd  = resp1_valid ? resp1_rdata : resp0_rdata;
                er  = resp1_valid ? resp1_err : resp0_err;
                t   = cyc;
            end
        end
        check("resp_wait", 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int          id;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        int          ar_w, aw_w, w_w;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t1, sid, h_ar, h_aw, h_w;
        int ids [4];
        int ts [4];
        int exp_ids [4];
        logic [31:0] rd;
        logic er;
        bit ok_v, ok_a, ok_r;

        vecs[0] = '{1, 1'b1, 12'h004, 32'h0000_0055, 4'h1, 32'h0000_0BAD, RESP_OKAY,   0, 2, 0, 32'h0000_0004, 32'h0, 1'b0};
        vecs[1] = '{0, 1'b0, 12'h00C, 32'h0,         4'h0, 32'hDEAD_BEEF, RESP_SLVERR, 1, 0, 0, 32'h0000_000C, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{1, 1'b1, 12'h008, 32'h1234_5678, 4'hF, 32'h0000_0BAD, RESP_DECERR, 0, 0, 0, 32'h0000_0008, 32'h0, 1'b1};
        vecs[3] = '{1, 1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_1234, RESP_EXOKAY, 0, 0, 0, 32'h0000_0000, 32'h0000_1234, 1'b0};
        vecs[4] = '{0, 1'b1, 12'h00C, 32'hA5A5_0000, 4'hC, 32'h0000_0BAD, RESP_SLVERR, 0, 0, 3, 32'h0000_000C, 32'h0, 1'b1};
        vecs[5] = '{0, 1'b0, 12'hFFC, 32'h0,         4'h0, 32'hFFFF_FFFF, RESP_OKAY,   0, 0, 0, 32'h0000_0FFC, 32'hFFFF_FFFF, 1'b0};

        do_reset();
        #1;
        check("rst_outs", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                               resp0_valid, resp1_valid, req0_ready, req1_ready, resp0_err, resp1_err}), 32'd0);
        check("rst_araddr", m_araddr, 32'h0);
        check("rst_rdata", resp0_rdata, 32'h0);

        // Zero-wait read: arvalid at T+1, response at T+3, single-cycle pulse.
        cfg_rdata = 32'h0000_0041; cfg_resp = RESP_OKAY;
        @(negedge clk); drive_req(0, 1'b1, 1'b0, 12'h008, 32'h0, 4'h0);
        wait_ready(0, t0);
        @(negedge clk); #1; drive_req(0, 1'b0, 1'b0, 12'h008, 32'h0, 4'h0);
        check("t1_arvalid", 32'(m_arvalid), 32'd1);
        check("t1_araddr", m_araddr, 32'h0000_0008);
        wait_resp(sid, rd, er, t1);
        check("t1_id", 32'(sid), 32'd0);
        check("t1_latency", 32'(t1 - t0), 32'd3);
        check("t1_rdata", rd, 32'h0000_0041);
        check("t1_err", 32'(er), 32'd0);
        @(negedge clk); #1;
        check("t1_pulse_len", 32'({resp0_valid, resp1_valid}), 32'd0);

        // Write with independent W (T+1) and AW (T+3) handshakes.
        cfg_aw_wait = 2; cfg_w_wait = 0; cfg_resp = RESP_OKAY;
        h_aw = aw_hs; h_w = w_hs;
        @(negedge clk); drive_req(1, 1'b1, 1'b1, 12'h004, 32'h0000_0055, 4'h1);
        wait_ready(1, t0);
        @(negedge clk); #1; drive_req(1, 1'b0, 1'b1, 12'h004, 32'h0000_0055, 4'h1);
        check("t2_T1_valids", 32'({m_awvalid, m_wvalid}), 32'b11);
        @(negedge clk); #1;
        check("t2_T2_valids", 32'({m_awvalid, m_wvalid}), 32'b10);
        @(negedge clk); #1;
        check("t2_T3_valids", 32'({m_awvalid, m_wvalid}), 32'b10);
        @(negedge clk); #1;
        check("t2_T4_state", 32'({m_awvalid, m_wvalid, m_bready}), 32'b001);
        wait_resp(sid, rd, er, t1);
        check("t2_id", 32'(sid), 32'd1);
        check("t2_latency", 32'(t1 - t0), 32'd5);
        check("t2_err", 32'(er), 32'd0);
        check("t2_aw_count", 32'(aw_hs - h_aw), 32'd1);
        check("t2_w_count", 32'(w_hs - h_w), 32'd1);
        check("t2_wdata", last_wdata, 32'h0000_0055);

        for (int i = 0; i < 6; i++) begin
            cfg_ar_wait = vecs[i].ar_w; cfg_aw_wait = vecs[i].aw_w; cfg_w_wait = vecs[i].w_w;
            cfg_rdata = vecs[i].s_rdata; cfg_resp = vecs[i].s_resp;
            h_ar = ar_hs; h_aw = aw_hs; h_w = w_hs;
            @(negedge clk);
            drive_req(vecs[i].id, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            wait_ready(vecs[i].id, t0);
            @(negedge clk);
            drive_req(vecs[i].id, 1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            wait_resp(sid, rd, er, t1);
            check($sformatf("v%0d_id", i), 32'(sid), 32'(vecs[i].id));
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            if (vecs[i].we) begin
                check($sformatf("v%0d_awaddr", i), last_awaddr, vecs[i].exp_addr);
                check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wdata);
                check($sformatf("v%0d_wstrb", i), 32'(last_wstrb), 32'(vecs[i].wstrb));
                check($sformatf("v%0d_hs", i), 32'({8'(aw_hs - h_aw), 8'(w_hs - h_w), 8'(ar_hs - h_ar)}), 32'h010100);
            end else begin
                check($sformatf("v%0d_araddr", i), last_araddr, vecs[i].exp_addr);
                check($sformatf("v%0d_hs", i), 32'({8'(aw_hs - h_aw), 8'(w_hs - h_w), 8'(ar_hs - h_ar)}), 32'h000001);
            end
        end

        // Both requesters continuously valid after reset.
        cfg_ar_wait = 0; cfg_aw_wait = 0; cfg_w_wait = 0;
        cfg_rdata = 32'h0000_0099; cfg_resp = RESP_OKAY;
        do_reset();
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        drive_req(1, 1'b1, 1'b0, 12'h014, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            wait_resp(sid, rd, er, t1);
            ids[k] = sid; ts[k] = t1;
        end
        drive_req(0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
        drive_req(1, 1'b0, 1'b0, 12'h014, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_grant%0d", k), 32'(ids[k]), 32'(exp_ids[k]));
            if (k > 0) check($sformatf("t3_spacing%0d", k), 32'(ts[k] - ts[k-1]), 32'd4);
        end

        // AR backpressure for 10 cycles with the other requester waiting.
        cfg_ar_wait = 10; cfg_rdata = 32'h0000_00AB;
        @(negedge clk); @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 12'h01C, 32'h0, 4'h0);
        wait_ready(0, t0);
        @(negedge clk); #1;
        drive_req(0, 1'b0, 1'b0, 12'h01C, 32'h0, 4'h0);
        drive_req(1, 1'b1, 1'b0, 12'h018, 32'h0, 4'h0);
        ok_v = 1'b1; ok_a = 1'b1; ok_r = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (m_arvalid !== 1'b1) ok_v = 1'b0;
            if (m_araddr !== 32'h0000_001C) ok_a = 1'b0;
            if (req1_ready !== 1'b0) ok_r = 1'b0;
            @(negedge clk);
        end
        check("t5_arvalid_held", 32'(ok_v), 32'd1);
        check("t5_araddr_stable", 32'(ok_a), 32'd1);
        check("t5_req1_blocked", 32'(ok_r), 32'd1);
        wait_resp(sid, rd, er, t1);
        check("t5_id0", 32'(sid), 32'd0);
        check("t5_latency", 32'(t1 - t0), 32'd13);
        cfg_ar_wait = 0; cfg_rdata = 32'h0000_00CD;
        wait_ready(1, t0);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 12'h018, 32'h0, 4'h0);
        wait_resp(sid, rd, er, t1);
        check("t5_id1", 32'(sid), 32'd1);
        check("t5_rdata1", rd, 32'h0000_00CD);

        // Reset while waiting for R data that never arrives.
        cfg_rvalid_en = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 12'h008, 32'h0, 4'h0);
        wait_ready(0, t0);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 12'h008, 32'h0, 4'h0);
        @(negedge clk); #1;
        check("t6_in_rd_d", 32'(m_rready), 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        check("t6_rst_outs", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                                  resp0_valid, resp1_valid, req0_ready, req1_ready}), 32'd0);
        rst = 1'b1; cfg_rvalid_en = 1'b1; cfg_rdata = 32'h0000_0077; cfg_resp = RESP_OKAY;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 12'h008, 32'h0, 4'h0);
        wait_ready(0, t0);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 12'h008, 32'h0, 4'h0);
        wait_resp(sid, rd, er, t1);
        check("t6_id", 32'(sid), 32'd0);
        check("t6_latency", 32'(t1 - t0), 32'd3);
        check("t6_rdata", rd, 32'h0000_0077);
        check("t6_err", 32'(er), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
